systolic_pe: RTL and testbench

SYSTOLIC_PE -- requirements
Module: systolic_pe

---
 rtl/systolic_pe_pkg.sv | 11 +
 rtl/pe_sat_add.sv | 29 ++
 rtl/systolic_pe.sv | 154 +++++++++++++++
 tb/tb_systolic_pe.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/systolic_pe_pkg.sv
// Shared constants for systolic PE arrays: FSM encoding and default widths.
package systolic_pe_pkg;

  localparam int unsigned DEFAULT_DATA_W = 16;
  localparam int unsigned DEFAULT_ACC_W  = 32;

  // Dot-product FSM encoding
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACC  = 1'b1;

endpackage

// File: rtl/pe_sat_add.sv
// Signed W-bit saturating adder.
// Ports: a, b   - signed addends
//        sum_c  - sum clamped to signed W-bit bounds (combinational)
//        ovf_c  - high when the true sum was clamped (combinational)
module pe_sat_add #(
  parameter int unsigned W = 32
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum_c,
  output logic                ovf_c
);

  logic signed [W:0] full;

  // One extra bit holds the exact sum; the top two bits disagree on overflow
  always_comb begin
    full  = (W+1)'(a) + (W+1)'(b);
    ovf_c = full[W] ^ full[W-1];
    if (!ovf_c) begin
      sum_c = full[W-1:0];
    end else if (full[W]) begin
      sum_c = {1'b1, {(W-1){1'b0}}};
    end else begin
      sum_c = {1'b0, {(W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/systolic_pe.sv
// Systolic processing element: forwards operands east/south and accumulates
// framed dot products with saturation and a held-result handshake.
// Ports: clk, reset (async active-low)
//        in_a/in_b/in_valid/in_first/in_last  - operand stream
//        out_a/out_b/out_valid/out_first/out_last - 1-cycle forwarded stream
//        out_z/out_sat/out_z_valid/out_z_ready - result and handshake
//        proto_err, overrun                   - sticky error flags
module systolic_pe
  import systolic_pe_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned ACC_W  = DEFAULT_ACC_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] in_a,
  input  logic signed [DATA_W-1:0] in_b,
  input  logic                     in_valid,
  input  logic                     in_first,
  input  logic                     in_last,
  output logic signed [DATA_W-1:0] out_a,
  output logic signed [DATA_W-1:0] out_b,
  output logic                     out_valid,
  output logic                     out_first,
  output logic                     out_last,
  output logic signed [ACC_W-1:0]  out_z,
  output logic                     out_z_valid,
  input  logic                     out_z_ready,
  output logic                     out_sat,
  output logic                     proto_err,
  output logic                     overrun
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  if (ACC_W < PROD_W) begin : g_width_check
    $error("systolic_pe: ACC_W must be at least 2*DATA_W");
  end

  // Stage 1 registers
  logic signed [ACC_W-1:0] p1;
  logic                    v1, f1, l1;

  // Stage 2 registers
  logic [0:0]              state, state_nxt;
  logic signed [ACC_W-1:0] acc, acc_nxt;
  logic                    sat, sat_nxt;
  logic                    done, done_nxt;
  logic                    perr_nxt;

  logic signed [PROD_W-1:0] prod_c;
  logic signed [ACC_W-1:0]  sum_c;
  logic                     ovf_c;

  assign prod_c = PROD_W'(in_a) * PROD_W'(in_b);

  pe_sat_add #(.W(ACC_W)) u_sat_add (
    .a     (acc),
    .b     (p1),
    .sum_c (sum_c),
    .ovf_c (ovf_c)
  );

  // Forwarding and stage-1 product registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_a     <= '0;
      out_b     <= '0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      p1        <= '0;
      v1        <= 1'b0;
      f1        <= 1'b0;
      l1        <= 1'b0;
    end else begin
      out_a     <= in_a;
      out_b     <= in_b;
      out_valid <= in_valid;
      out_first <= in_first;
      out_last  <= in_last;
      p1        <= ACC_W'(prod_c);
      v1        <= in_valid;
      f1        <= in_valid & in_first;
      l1        <= in_valid & in_last;
    end
  end

  // Stage-2 next state: accumulate, framing checks, result completion
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    sat_nxt   = sat;
    done_nxt  = 1'b0;
    perr_nxt  = proto_err;
    if (v1) begin
      if (f1) begin
        // A first inside an open dot product abandons the partial sum
        if (state == ST_ACC) perr_nxt = 1'b1;
        acc_nxt = p1;
        sat_nxt = 1'b0;
        if (l1) begin
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_ACC;
        end
      end else if (state == ST_IDLE) begin
        perr_nxt = 1'b1;
      end else begin
        acc_nxt = sum_c;
        sat_nxt = sat | ovf_c;
        if (l1) begin
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
    end
  end

  // Stage-2 state register and result output stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      acc         <= '0;
      sat         <= 1'b0;
      done        <= 1'b0;
      proto_err   <= 1'b0;
      out_z       <= '0;
      out_sat     <= 1'b0;
      out_z_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      sat       <= sat_nxt;
      done      <= done_nxt;
      proto_err <= perr_nxt;
      if (done) begin
        // A stalled consumer keeps its held result; the new one is lost
        if (out_z_valid && !out_z_ready) begin
          overrun <= 1'b1;
        end else begin
          out_z       <= acc;
          out_sat     <= sat;
          out_z_valid <= 1'b1;
        end
      end else if (out_z_valid && out_z_ready) begin
        out_z_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_systolic_pe.sv
// Directed self-checking bench for systolic_pe (DATA_W=16, ACC_W=32).
module tb_systolic_pe;

  logic               clk;
  logic               reset;
  logic signed [15:0] in_a, in_b;
  logic               in_valid, in_first, in_last;
  logic signed [15:0] out_a, out_b;
  logic               out_valid, out_first, out_last;
  logic signed [31:0] out_z;
  logic               out_z_valid, out_z_ready, out_sat, proto_err, overrun;

  int vectors;
  int miscompares;

  systolic_pe #(.DATA_W(16), .ACC_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_valid    (in_valid),
    .in_first    (in_first),
    .in_last     (in_last),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_valid   (out_valid),
    .out_first   (out_first),
    .out_last    (out_last),
    .out_z       (out_z),
    .out_z_valid (out_z_valid),
    .out_z_ready (out_z_ready),
    .out_sat     (out_sat),
    .proto_err   (proto_err),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("miscompare on %s", tag);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b,
                       input logic v, input logic f, input logic l);
    in_a     = a;
    in_b     = b;
    in_valid = v;
    in_first = f;
    in_last  = l;
  endtask

  // Advance one edge and settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    out_z_ready = 1'b1;
    drive(16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk("rst_out_z", out_z, 32'd0);
    chk("rst_out_z_valid", {31'd0, out_z_valid}, 32'd0);
    chk("rst_flags", {30'd0, proto_err, overrun}, 32'd0);
    chk("rst_out_a", {16'd0, out_a}, 32'd0);
    reset = 1'b1;

    // Single-element dot product (3,4)
    drive(16'd3, 16'd4, 1'b1, 1'b1, 1'b1);
    tick();
    chk("fwd_a", {16'd0, out_a}, 32'd3);
    chk("fwd_b", {16'd0, out_b}, 32'd4);
    chk("fwd_ctl", {29'd0, out_valid, out_first, out_last}, 32'd7);
    chk("z_valid_k", {31'd0, out_z_valid}, 32'd0);
    drive(16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("fwd_idle", {29'd0, out_valid, out_first, out_last}, 32'd0);
    chk("z_valid_k1", {31'd0, out_z_valid}, 32'd0);
    tick();
    chk("z_valid_k2", {31'd0, out_z_valid}, 32'd1);
    chk("z_3x4", out_z, 32'd12);
    chk("sat_3x4", {31'd0, out_sat}, 32'd0);
    tick();
    chk("z_valid_pulse_end", {31'd0, out_z_valid}, 32'd0);

    // (2,3) first, (-1,5), bubble, (4,4) last -> 6-5+16 = 17
    drive(16'd2, 16'd3, 1'b1, 1'b1, 1'b0);
    tick();
    drive(16'hFFFF, 16'd5, 1'b1, 1'b0, 1'b0);
    tick();
    drive(16'd9, 16'd9, 1'b0, 1'b0, 1'b0);
    tick();
    drive(16'd4, 16'd4, 1'b1, 1'b0, 1'b1);
    tick();
    drive(16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk("dp4_valid", {31'd0, out_z_valid}, 32'd1);
    chk("dp4_z", out_z, 32'd17);
    chk("dp4_sat", {31'd0, out_sat}, 32'd0);
    tick();

    // 3 x 0x3FFF0001 exceeds INT32_MAX -> clamp
    drive(16'h7FFF, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    tick();
    drive(16'h7FFF, 16'h7FFF, 1'b1, 1'b0, 1'b0);
    tick();
    drive(16'h7FFF, 16'h7FFF, 1'b1, 1'b0, 1'b1);
    tick();
    drive(16'd1, 16'd1, 1'b1, 1'b1, 1'b1);
    tick();
    drive(16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("sat_z", out_z, 32'h7FFF_FFFF);
    chk("sat_flag", {31'd0, out_sat}, 32'd1);
    tick();
    chk("after_sat_z", out_z, 32'd1);
    chk("after_sat_flag", {31'd0, out_sat}, 32'd0);
    chk("after_sat_valid", {31'd0, out_z_valid}, 32'd1);
    tick();
    chk("no_overrun_yet", {31'd0, overrun}, 32'd0);

    // Stalled consumer: second result dropped, overrun set
    out_z_ready = 1'b0;
    drive(16'd2, 16'd2, 1'b1, 1'b1, 1'b1);
    tick();
    drive(16'd5, 16'd5, 1'b1, 1'b1, 1'b1);
    tick();
    drive(16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("stall_z_first", out_z, 32'd4);
    tick();
    chk("stall_z_held", out_z, 32'd4);
    chk("stall_overrun", {31'd0, overrun}, 32'd1);
    chk("stall_valid", {31'd0, out_z_valid}, 32'd1);
    tick();
    chk("stall_hold2", out_z, 32'd4);
    out_z_ready = 1'b1;
    tick();
    chk("stall_release", {31'd0, out_z_valid}, 32'd0);
    chk("overrun_sticky", {31'd0, overrun}, 32'd1);

    // Element without first while idle -> discarded, proto_err
    drive(16'd7, 16'd7, 1'b1, 1'b0, 1'b1);
    tick();
    drive(16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk("perr_set", {31'd0, proto_err}, 32'd1);
    chk("perr_no_result", {31'd0, out_z_valid}, 32'd0);
    tick();
    chk("perr_no_result2", {31'd0, out_z_valid}, 32'd0);

    // Asynchronous reset in the middle of a dot product
    drive(16'd3, 16'd3, 1'b1, 1'b1, 1'b0);
    tick();
    drive(16'd1, 16'd1, 1'b1, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    chk("arst_out_a", {16'd0, out_a}, 32'd0);
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_out_z", out_z, 32'd0);
    chk("arst_flags", {30'd0, proto_err, overrun}, 32'd0);
    drive(16'd1, 16'd2, 1'b1, 1'b1, 1'b1);
    #1;
    reset = 1'b1;
    tick();
    drive(16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk("post_rst_valid", {31'd0, out_z_valid}, 32'd1);
    chk("post_rst_z", out_z, 32'd2);
    chk("post_rst_perr", {31'd0, proto_err}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
